// File: rtl/mul_pipe.sv
// Two-stage pipelined multiplier with RISC-V style MUL/MULH/MULHSU/MULHU selection.
// Stage 1 registers sign-stripped operands; stage 2 registers the selected product half.

module mul_pipe_array #(
    parameter int WIDTH        = 8,
    parameter bit BEHAVIORAL   = 1'b0,
    parameter bit RIPPLE_CARRY = 1'b1
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] p
);

    generate
        if (BEHAVIORAL) begin : g_behav
            assign p = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        end else if (RIPPLE_CARRY) begin : g_ripple
            logic [2*WIDTH-1:0] acc;
            logic [2*WIDTH-1:0] row;
            logic               carry;
            logic               sum;

            // Each partial-product row is folded into the accumulator by a bit-serial ripple adder.
            always_comb begin
                acc   = '0;
                row   = '0;
                carry = 1'b0;
                sum   = 1'b0;
                for (int i = 0; i < WIDTH; i++) begin
                    row   = b[i] ? ({{WIDTH{1'b0}}, a} << i) : '0;
                    carry = 1'b0;
                    for (int j = 0; j < 2*WIDTH; j++) begin
                        sum    = acc[j] ^ row[j] ^ carry;
                        carry  = (acc[j] & row[j]) | (carry & (acc[j] ^ row[j]));
                        acc[j] = sum;
                    end
                end
                p = acc;
            end
        end else begin : g_csa
            logic [2*WIDTH-1:0] s;
            logic [2*WIDTH-1:0] c;
            logic [2*WIDTH-1:0] row;
            logic [2*WIDTH-1:0] ns;
            logic [2*WIDTH-1:0] nc;

            // Carry-save reduction; only the final sum/carry pair goes through a full adder.
            always_comb begin
                s   = '0;
                c   = '0;
                row = '0;
                ns  = '0;
                nc  = '0;
                for (int i = 0; i < WIDTH; i++) begin
                    row = b[i] ? ({{WIDTH{1'b0}}, a} << i) : '0;
                    ns  = s ^ c ^ row;
                    nc  = ((s & c) | (s & row) | (c & row)) << 1;
                    s   = ns;
                    c   = nc;
                end
                p = s + c;
            end
        end
    endgenerate

endmodule

module mul_pipe #(
    parameter int WIDTH        = 8,
    parameter int TAG_WIDTH    = 5,
    parameter bit BEHAVIORAL   = 1'b0,
    parameter bit RIPPLE_CARRY = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_op,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic [TAG_WIDTH-1:0] in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_result,
    output logic [TAG_WIDTH-1:0] out_tag
);

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;

    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                   input logic as_signed);
        return (as_signed && v[WIDTH-1]) ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] v,
                                                      input logic neg);
        return neg ? (~v + (2*WIDTH)'(1)) : v;
    endfunction

    logic                 signed_a;
    logic                 signed_b;
    logic                 adv_p1;
    logic                 adv_p2;

    logic                 vld_p1;
    logic [WIDTH-1:0]     mag_a_p1;
    logic [WIDTH-1:0]     mag_b_p1;
    logic                 neg_p1;
    logic [1:0]           op_p1;
    logic [TAG_WIDTH-1:0] tag_p1;

    logic [2*WIDTH-1:0]   prod_raw_p1;
    logic [2*WIDTH-1:0]   prod_p1;
    logic [WIDTH-1:0]     result_p1;

    logic                 vld_p2;
    logic [WIDTH-1:0]     res_p2;
    logic [TAG_WIDTH-1:0] tag_p2;

    assign signed_a = (in_op == OP_MULH) || (in_op == OP_MULHSU);
    assign signed_b = (in_op == OP_MULH);

    assign adv_p2   = !vld_p2 || out_ready;
    assign adv_p1   = !vld_p1 || adv_p2;
    assign in_ready = adv_p1;

    // Stage 1: operand magnitudes, negate flag, op and tag
    always_ff @(posedge clk) begin
        if (adv_p1 && in_valid) begin
            mag_a_p1 <= magnitude(in_a, signed_a);
            mag_b_p1 <= magnitude(in_b, signed_b);
            neg_p1   <= (signed_a & in_a[WIDTH-1]) ^ (signed_b & in_b[WIDTH-1]);
            op_p1    <= in_op;
            tag_p1   <= in_tag;
        end
    end

    mul_pipe_array #(
        .WIDTH        (WIDTH),
        .BEHAVIORAL   (BEHAVIORAL),
        .RIPPLE_CARRY (RIPPLE_CARRY)
    ) u_array (
        .a (mag_a_p1),
        .b (mag_b_p1),
        .p (prod_raw_p1)
    );

    assign prod_p1   = apply_sign(prod_raw_p1, neg_p1);
    assign result_p1 = (op_p1 == OP_MUL) ? prod_p1[WIDTH-1:0] : prod_p1[2*WIDTH-1:WIDTH];

    // Stage 2: selected product half and tag; output registers clear on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            res_p2 <= '0;
            tag_p2 <= '0;
        end else begin
            if (adv_p1) begin
                vld_p1 <= in_valid;
            end
            if (adv_p2) begin
                vld_p2 <= vld_p1;
                if (vld_p1) begin
                    res_p2 <= result_p1;
                    tag_p2 <= tag_p1;
                end
            end
        end
    end

    assign out_valid  = vld_p2;
    assign out_result = res_p2;
    assign out_tag    = tag_p2;

endmodule

// File: tb/tb_mul_pipe.sv
// Bench for mul_pipe: directed product cases, streaming, backpressure, reset and random traffic
// checked against an integer-arithmetic reference model with an in-order scoreboard.

module tb_mul_pipe;

    localparam int W  = 8;
    localparam int TW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:0]    in_op = 2'b00;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic [TW-1:0] in_tag = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  out_result;
    logic [TW-1:0] out_tag;

    typedef struct {
        logic [W-1:0]  res;
        logic [TW-1:0] tag;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_chk = 0;
    int   n_pass = 0;
    int   n_out = 0;

    mul_pipe #(
        .WIDTH        (W),
        .TAG_WIDTH    (TW),
        .BEHAVIORAL   (1'b0),
        .RIPPLE_CARRY (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    // Reference: interpret operands as integers, multiply, pick the half.
    function automatic logic [W-1:0] ref_mul(input logic [1:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        int          av;
        int          bv;
        int          p;
        logic [31:0] pu;
        av = int'(a);
        bv = int'(b);
        if ((op == 2'd1 || op == 2'd2) && a[W-1]) av = av - (1 << W);
        if (op == 2'd1 && b[W-1]) bv = bv - (1 << W);
        p  = av * bv;
        pu = p;
        return (op == 2'd0) ? pu[W-1:0] : pu[2*W-1:W];
    endfunction

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 8'h80;
            1:       return 8'hFF;
            2:       return 8'h7F;
            3:       return 8'h00;
            4:       return 8'h01;
            default: return W'($urandom);
        endcase
    endfunction

    task automatic set_input(input logic v, input logic [1:0] op, input logic [W-1:0] a,
                             input logic [W-1:0] b, input logic [TW-1:0] tag);
        in_valid = v;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
    endtask

    // Scoreboard: transfers are sampled mid-cycle, ahead of the edge that performs them.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_out++;
                check("out_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    check("mon_result", 32'(out_result), 32'(mon_e.res));
                    check("mon_tag", 32'(out_tag), 32'(mon_e.tag));
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back('{ref_mul(in_op, in_a, in_b), in_tag});
            end
        end
    end

    task automatic run_one(input string name, input logic [1:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [TW-1:0] tag,
                           input logic [W-1:0] expv);
        @(posedge clk); #1;
        out_ready = 1'b1;
        set_input(1'b1, op, a, b, tag);
        @(negedge clk);
        check({name, "_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check({name, "_lat1"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        check({name, "_valid"}, 32'(out_valid), 32'd1);
        check({name, "_result"}, 32'(out_result), 32'(expv));
        check({name, "_tag"}, 32'(out_tag), 32'(tag));
    endtask

    logic [1:0]   bp_op[3];
    logic [W-1:0] bp_a[3];
    logic [W-1:0] bp_b[3];
    int           n_out0;

    initial begin
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_result", 32'(out_result), 32'd0);
        check("rst_out_tag", 32'(out_tag), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(in_ready), 32'd1);

        run_one("mul_0f", 2'd0, 8'h0F, 8'h0F, 5'd3, 8'hE1);
        run_one("mulh_80_80", 2'd1, 8'h80, 8'h80, 5'd4, 8'h40);
        run_one("mulh_ff_01", 2'd1, 8'hFF, 8'h01, 5'd5, 8'hFF);
        run_one("mulh_7f_80", 2'd1, 8'h7F, 8'h80, 5'd6, 8'hC0);
        run_one("mulhsu_ff_ff", 2'd2, 8'hFF, 8'hFF, 5'd7, 8'hFF);
        run_one("mulhu_ff_ff", 2'd3, 8'hFF, 8'hFF, 5'd8, 8'hFE);
        run_one("mulhsu_01_80", 2'd2, 8'h01, 8'h80, 5'd9, 8'h00);
        run_one("mul_ff_ff", 2'd0, 8'hFF, 8'hFF, 5'd10, 8'h01);

        // Back-to-back stream of 10 with the sink always ready.
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (i < 10) set_input(1'b1, 2'($urandom_range(0, 3)), pick_operand(), pick_operand(), TW'(i));
            else in_valid = 1'b0;
            @(negedge clk);
            if (i < 10) check("stream_ready", 32'(in_ready), 32'd1);
            if (i >= 2) begin
                check("stream_valid", 32'(out_valid), 32'd1);
                check("stream_tag", 32'(out_tag), 32'(i - 2));
            end
        end

        // Three inputs, then the sink stalls for four cycles.
        for (int k = 0; k < 3; k++) begin
            bp_op[k] = 2'($urandom_range(0, 3));
            bp_a[k]  = pick_operand();
            bp_b[k]  = pick_operand();
        end
        @(posedge clk); #1;
        n_out0 = n_out;
        for (int i = 0; i < 11; i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
            end
            if (i < 3) set_input(1'b1, bp_op[i], bp_a[i], bp_b[i], TW'(20 + i));
            if (i == 7) in_valid = 1'b0;
            out_ready = !(i >= 2 && i <= 5);
            @(negedge clk);
            if (i >= 2 && i <= 5) begin
                check("bp_valid", 32'(out_valid), 32'd1);
                check("bp_result", 32'(out_result), 32'(ref_mul(bp_op[0], bp_a[0], bp_b[0])));
                check("bp_tag", 32'(out_tag), 32'd20);
                check("bp_ready", 32'(in_ready), 32'd0);
            end
        end
        check("bp_count", 32'(n_out - n_out0), 32'd3);
        check("bp_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset with two operations in flight.
        out_ready = 1'b1;
        @(posedge clk); #1;
        set_input(1'b1, 2'd0, 8'h11, 8'h22, 5'd1);
        @(posedge clk); #1;
        set_input(1'b1, 2'd3, 8'h33, 8'h44, 5'd2);
        @(posedge clk); #1;
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_result", 32'(out_result), 32'd0);
        check("midrst_tag", 32'(out_tag), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        n_out0 = n_out;
        set_input(1'b1, 2'd1, 8'hFE, 8'h03, 5'd17);
        @(negedge clk);
        check("relrst_ready", 32'(in_ready), 32'd1);
        check("relrst_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("relrst_lat1", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("relrst_out_valid", 32'(out_valid), 32'd1);
        check("relrst_result", 32'(out_result), 32'hFF);
        check("relrst_tag", 32'(out_tag), 32'd17);
        repeat (3) @(negedge clk);
        check("relrst_no_stale", 32'(n_out - n_out0), 32'd1);

        // Random traffic with random backpressure.
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            set_input($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), pick_operand(),
                      pick_operand(), TW'($urandom));
            out_ready = $urandom_range(0, 3) != 0;
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        check("drain_idle", 32'(out_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mul_pipe.md
MUL_PIPE -- requirements
Module: mul_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand width in bits, with a minimum of 2.
REQ-002 SHALL have parameter TAG_WIDTH, default 5: width of the destination tag carried alongside each operation.
REQ-003 SHALL have parameter BEHAVIORAL, default 1'b0: passed unchanged to the internal array multiplier.
REQ-004 SHALL have parameter RIPPLE_CARRY, default 1'b1: passed unchanged to the internal array multiplier.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port in_valid, input, 1 bit: the upstream operation is valid.
REQ-008 SHALL have port in_ready, output, 1 bit: the block accepts an operation this cycle.
REQ-009 SHALL have port in_op, input, 2 bits: 00 MUL (low half), 01 MULH (signed x signed, high half), 10 MULHSU (signed A x unsigned B, high half), 11 MULHU (unsigned x unsigned, high half).
REQ-010 SHALL have port in_a, input, WIDTH bits: operand A.
REQ-011 SHALL have port in_b, input, WIDTH bits: operand B.
REQ-012 SHALL have port in_tag, input, TAG_WIDTH bits: destination tag.
REQ-013 SHALL have port out_valid, output, 1 bit: a result is present.
REQ-014 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-015 SHALL have port out_result, output, WIDTH bits: the selected half of the product.
REQ-016 SHALL have port out_tag, output, TAG_WIDTH bits: the tag of the result.

Function
REQ-017 SHALL transfer an input when in_valid && in_ready at a rising edge, and an output when out_valid && out_ready at a rising edge.
REQ-018 SHALL use a two-register pipeline:
- S1 holds magnitudes |A| and |B|, negate flag, op and tag.
- S2 holds the final WIDTH-bit result and tag.
- Each stage has its own valid bit.
REQ-019 SHALL compute the S1 magnitudes as follows:
- An operand treated as signed with MSB=1 SHALL be stored as its two's complement, zero-extended to WIDTH bits; -2^(WIDTH-1) maps to 2^(WIDTH-1) exactly.
- Any other operand SHALL be stored unchanged.
REQ-020 SHALL treat operands as signed as follows:
- MULH: both A and B.
- MULHSU: A only.
- MUL and MULHU: neither.
REQ-021 SHALL set the S1 negate flag to (signed-A MSB) XOR (signed-B MSB), counting only operands treated as signed.
REQ-022 SHALL form the 2*WIDTH product combinationally between S1 and S2 from the S1 magnitudes, using the internal unsigned array multiplier with BEHAVIORAL and RIPPLE_CARRY passed through.
REQ-023 SHALL two's-complement negate the 2*WIDTH product over the full 2*WIDTH bits when the negate flag is set.
REQ-024 SHALL load S2 with bits [WIDTH-1:0] of the product for MUL, and bits [2*WIDTH-1:WIDTH] otherwise.
REQ-025 SHALL give the MUL low half identical to an unsigned multiply, since the negate flag is always 0 for MUL.
REQ-026 SHALL have a latency of exactly 2 cycles from input acceptance to out_valid when out_ready is held high.
REQ-027 SHALL sustain a throughput of one operation per cycle when out_ready is held high.
REQ-028 SHALL advance S2 when (!S2 valid || out_ready).
REQ-029 SHALL advance S1 when (!S1 valid || S2 advances).
REQ-030 SHALL drive in_ready equal to the S1 advance condition; in_ready SHALL depend combinationally only on state and out_ready, never on in_valid.
REQ-031 SHALL, when out_valid=1 and out_ready=0, hold out_result, out_tag and out_valid stable, hold S1 stable, and deassert in_ready if S1 is valid.
REQ-032 SHALL, on a simultaneous output transfer and S1 to S2 move in one cycle, present the S1 operation as the new output with no bubble.
REQ-033 SHALL clear a stage valid bit when that stage advances with no incoming data.
REQ-034 SHALL keep stage data registers unchanged while the stage holds.
REQ-035 SHALL deliver results in acceptance order, with each tag delivered alongside its own result.

Reset
REQ-036 SHALL, while rst_n=0, immediately force out_valid=0 and both stage valid bits to 0, independent of clk.
REQ-037 SHALL force out_result=0 and out_tag=0 while rst_n=0.
REQ-038 SHALL drop any in-flight operations when reset is asserted mid-operation, with no output produced for them.
REQ-039 SHALL, after reset, allow in_ready=1 and accept an input on the first rising edge following rst_n rising.

Verification (WIDTH=8)
REQ-040 SHALL be verified with the MUL scenario: MUL 0x0F x 0x0F, out_ready=1 -> out_result=0xE1 exactly 2 cycles after acceptance, tag preserved.
REQ-041 SHALL be verified with the signed scenarios:
- MULH 0x80 x 0x80 -> 0x40.
- MULH 0xFF x 0x01 -> 0xFF.
- MULH 0x7F x 0x80 -> 0xC0.
REQ-042 SHALL be verified with the mixed and unsigned scenarios:
- MULHSU 0xFF x 0xFF -> 0xFF.
- MULHU 0xFF x 0xFF -> 0xFE.
- MULHSU 0x01 x 0x80 -> 0x00.
REQ-043 SHALL be verified with a back-to-back stream of 10 operations with out_ready=1: one result per cycle, in order, with matching tags.
REQ-044 SHALL be verified with backpressure, applying 3 back-to-back inputs then out_ready=0 for 4 cycles:
- Cycle by cycle, out_result and out_tag stay stable and in_ready=0 once S1 is full.
- After out_ready rises, all 3 results emerge in order with none lost or duplicated.
REQ-045 SHALL be verified with reset mid-operation: assert rst_n=0 between clk edges with 2 operations in flight -> out_valid=0 immediately, and no stale result appears after release.
